// File: rtl/universal_shift_reg_param.sv
// Parametrised universal shift register: hold/shift/load/rotate/ASR/clear,
// with a saturating shift counter and a one-cycle done pulse for PISO use.
module universal_shift_reg_param #(
  parameter int unsigned          WIDTH     = 4,
  parameter logic [WIDTH-1:0]     RESET_VAL = '0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           en,
  input  logic [2:0]                     select,
  input  logic [WIDTH-1:0]               p_din,
  input  logic                           s_left_din,
  input  logic                           s_right_din,
  output logic [WIDTH-1:0]               p_dout,
  output logic                           s_left_dout,
  output logic                           s_right_dout,
  output logic [$clog2(WIDTH+1)-1:0]     shift_cnt,
  output logic                           shift_done
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {
    OP_HOLD = 3'b000,
    OP_SHR  = 3'b001,
    OP_SHL  = 3'b010,
    OP_LOAD = 3'b011,
    OP_ROR  = 3'b100,
    OP_ROL  = 3'b101,
    OP_ASR  = 3'b110,
    OP_CLR  = 3'b111
  } op_e;

  op_e              op;
  logic [WIDTH-1:0] q_q, q_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             is_shift;

  assign op = op_e'(select);

  always_comb begin
    q_d      = q_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    is_shift = 1'b0;
    case (op)
      OP_HOLD: q_d = q_q;
      OP_SHR: begin
        q_d      = {s_right_din, q_q[WIDTH-1:1]};
        is_shift = 1'b1;
      end
      OP_SHL: begin
        q_d      = {q_q[WIDTH-2:0], s_left_din};
        is_shift = 1'b1;
      end
      OP_LOAD: begin
        q_d   = p_din;
        cnt_d = '0;
      end
      OP_ROR: begin
        q_d      = {q_q[0], q_q[WIDTH-1:1]};
        is_shift = 1'b1;
      end
      OP_ROL: begin
        q_d      = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
        is_shift = 1'b1;
      end
      OP_ASR: begin
        q_d      = {q_q[WIDTH-1], q_q[WIDTH-1:1]};
        is_shift = 1'b1;
      end
      OP_CLR: begin
        q_d   = '0;
        cnt_d = '0;
      end
      default: q_d = q_q;
    endcase
    // Pulse only on the WIDTH-1 -> WIDTH transition; saturated shifts stay quiet.
    if (is_shift) begin
      if (cnt_q != CW'(WIDTH)) cnt_d = cnt_q + 1'b1;
      done_d = (cnt_q == CW'(WIDTH - 1));
    end
  end

  // done_q sits inside the enable, so it holds (and may stretch) while en=0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q    <= RESET_VAL;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else if (en) begin
      q_q    <= q_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign p_dout       = q_q;
  assign s_left_dout  = q_q[WIDTH-1];
  assign s_right_dout = q_q[0];
  assign shift_cnt    = cnt_q;
  assign shift_done   = done_q;

endmodule
